// File: rtl/ahblite_uart_pkg.sv
// Shared constants and types for the AHB-Lite UART register window.
package ahblite_uart_pkg;

  // Register offsets, decoded from HADDR[3:2]
  localparam logic [1:0] RX_DATA  = 2'd0;
  localparam logic [1:0] TX_STATE = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] RSVD     = 2'd3;

  // Bit positions inside the TX STATE register
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_RX_NONEMPTY = 3;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Registered address-phase information carried into the data phase
  typedef struct packed {
    logic       active;
    logic       write;
    logic [1:0] addr;
  } dphase_t;

  // True for the transfer types that carry data (NONSEQ/SEQ)
  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small single-clock FIFO with a show-ahead head output.
// Push and pop in the same cycle both take effect, even when full;
// a pop while empty is ignored. dout reads 0 while the FIFO is empty.
module uart_sync_fifo
  import ahblite_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty gates dout
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head of queue, forced to zero when nothing is stored
  always_comb begin
    dout = {WIDTH{1'b0}};
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/ahblite_uart_slave.sv
// AHB-Lite responder for the UART register window. Reads of RX DATA pop
// the receive FIFO, writes to TX DATA push the transmit FIFO, and a write
// into a full transmit FIFO is held with wait states until the core pops.
module ahblite_uart_slave
  import ahblite_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  dphase_t     dp;
  logic        accept;
  logic        rd_phase;
  logic        tx_wr;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_stall;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic        rx_drop;
  logic [7:0]  rx_head;
  logic        status_rd_done;
  logic        rx_overrun;
  logic [31:0] status_word;
  logic [31:0] rdata;
  logic        unused_bits;

  // Byte lane 0 only; size and the rest of the address are not decoded
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

  assign accept   = HSEL & is_transfer(HTRANS) & HREADY;
  assign rd_phase = dp.active & ~dp.write;
  assign tx_wr    = dp.active & dp.write & (dp.addr == TX_DATA);

  // A pop in the stalled cycle frees a slot, so the push can land at
  // the same edge and the wait state ends combinationally.
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_stall = tx_wr & tx_full & ~tx_pop;
  assign tx_push  = tx_wr & ~tx_stall;

  assign HREADYOUT = ~tx_stall;
  assign HRESP     = 1'b0;
  assign HRDATA    = rdata;

  assign rx_pop         = rd_phase & HREADYOUT & (dp.addr == RX_DATA) & ~rx_empty;
  assign rx_drop        = rx_valid & rx_full & ~rx_pop;
  assign status_rd_done = rd_phase & HREADYOUT & (dp.addr == TX_STATE);

  // Capture the address phase; hold it while the bus is stalled
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp <= '{active: 1'b0, write: 1'b0, addr: 2'd0};
    end else if (HREADY) begin
      dp.active <= accept;
      dp.write  <= HWRITE;
      dp.addr   <= HADDR[3:2];
    end else begin
      dp <= dp;
    end
  end

  // Sticky overrun flag; a new drop wins over a clearing status read
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rx_overrun <= 1'b0;
    end else if (rx_drop) begin
      rx_overrun <= 1'b1;
    end else if (status_rd_done) begin
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_overrun;
    end
  end

  // Assemble the TX STATE register
  always_comb begin
    status_word                 = 32'd0;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_TX_EMPTY]    = tx_empty;
    status_word[ST_RX_OVERRUN]  = rx_overrun;
    status_word[ST_RX_NONEMPTY] = ~rx_empty;
  end

  // Read data mux, zero outside an active read data phase
  always_comb begin
    rdata = 32'd0;
    if (rd_phase) begin
      case (dp.addr)
        RX_DATA:  rdata = {23'd0, ~rx_empty, rx_head};
        TX_STATE: rdata = status_word;
        default:  rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (HWDATA[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_ahblite_uart_slave.sv
// Directed testbench for ahblite_uart_slave (FIFO_DEPTH = 4).
module tb_ahblite_uart_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_RX = 32'h4000_0010;
  localparam logic [31:0] A_ST = 32'h4000_0014;
  localparam logic [31:0] A_TX = 32'h4000_0018;

  always #5 HCLK = ~HCLK;

  ahblite_uart_slave #(.FIFO_DEPTH(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADYOUT),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    cyc();
    idle_bus();
    @(negedge HCLK);
    d = HRDATA;
    cyc();
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    addr_phase(a, 1'b1);
    cyc();
    idle_bus();
    HWDATA = d;
    waits = 0;
    @(negedge HCLK);
    while (HREADYOUT !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge HCLK);
    end
    if (waits >= 50) begin
      checks++; failures++;
      $display("FAIL write_timeout: HREADYOUT=%b after %0d cycles, required 1", HREADYOUT, waits);
    end
    cyc();
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    HRESETn = 1'b0; idle_bus(); HSIZE = 3'd0; HWDATA = 32'd0;
    tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    cyc(); cyc(); cyc();
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRDATA, tx_valid, tx_data, HRESP} !== {1'b1, 32'd0, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: hreadyout=%b hrdata=%h tx_valid=%b tx_data=%h hresp=%b, required 1/0/0/0/0",
               HREADYOUT, HRDATA, tx_valid, tx_data, HRESP);
    end
    cyc();
    HRESETn = 1'b1;
    cyc();
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL reset_status: got %h, required 00000002", d); end
  endtask

  task automatic test_single_tx();
    int w;
    tx_ready = 1'b1;
    ahb_write(A_TX, 32'h0000_0041, w);
    checks++;
    if (w !== 0) begin failures++; $display("FAIL single_tx_waits: got %0d, required 0", w); end
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      failures++; $display("FAIL single_tx_out: tx_valid=%b tx_data=%h, required 1/41", tx_valid, tx_data);
    end
    cyc();
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_tx_popped: tx_valid=%b, required 0", tx_valid); end
    cyc();
  endtask

  task automatic test_tx_full_wait();
    int w;
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ahb_write(A_TX, i, w);
      checks++;
      if (w !== 0) begin failures++; $display("FAIL fill_waits%0d: got %0d, required 0", i, w); end
    end
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL tx_full_status: got %h, required 00000001", d); end
    addr_phase(A_TX, 1'b1);
    cyc();
    idle_bus();
    HWDATA = 32'd5;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL wait_state1: hreadyout=%b, required 0", HREADYOUT); end
    cyc();
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL wait_state2: hreadyout=%b, required 0", HREADYOUT); end
    tx_ready = 1'b1;
    #1;
    checks++;
    if (HREADYOUT !== 1'b1 || tx_data !== 8'd1) begin
      failures++; $display("FAIL wait_release: hreadyout=%b tx_data=%h, required 1/01", HREADYOUT, tx_data);
    end
    @(posedge HCLK);
    #1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge HCLK);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== k[7:0]) begin
        failures++; $display("FAIL tx_order%0d: tx_valid=%b tx_data=%h, required 1/%h", k, tx_valid, tx_data, k[7:0]);
      end
      @(posedge HCLK);
      #1;
    end
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained: tx_valid=%b, required 0", tx_valid); end
    cyc();
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    strobe(8'h55);
    strobe(8'hAA);
    ahb_read(A_RX, d);
    checks++;
    if (d !== 32'h155) begin failures++; $display("FAIL rx_read1: got %h, required 00000155", d); end
    ahb_read(A_RX, d);
    checks++;
    if (d !== 32'h1AA) begin failures++; $display("FAIL rx_read2: got %h, required 000001aa", d); end
    ahb_read(A_RX, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rx_read_empty: got %h, required 00000000", d); end
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rx_empty_status: got %h, required 00000002", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  bytes [5];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    for (int i = 0; i < 5; i++) strobe(bytes[i]);
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'hE) begin failures++; $display("FAIL overrun_set: got %h, required 0000000e", d); end
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL overrun_clear: got %h, required 0000000a", d); end
    for (int i = 0; i < 4; i++) begin
      ahb_read(A_RX, d);
      checks++;
      if (d !== {23'd0, 1'b1, bytes[i]}) begin
        failures++; $display("FAIL overrun_data%0d: got %h, required %h", i, d, {23'd0, 1'b1, bytes[i]});
      end
    end
    ahb_read(A_RX, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL overrun_lost: got %h, required 00000000", d); end
  endtask

  task automatic test_rx_simultaneous();
    logic [31:0] d;
    for (int i = 1; i <= 4; i++) strobe(8'h60 + i[7:0]);
    addr_phase(A_RX, 1'b0);
    cyc();
    idle_bus();
    rx_data = 8'h65; rx_valid = 1'b1;
    @(negedge HCLK);
    checks++;
    if (HRDATA !== 32'h161) begin failures++; $display("FAIL simul_read: got %h, required 00000161", HRDATA); end
    cyc();
    rx_valid = 1'b0;
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL simul_no_overrun: got %h, required 0000000a", d); end
    for (int i = 2; i <= 5; i++) begin
      ahb_read(A_RX, d);
      checks++;
      if (d !== (32'h160 + i)) begin
        failures++; $display("FAIL simul_data%0d: got %h, required %h", i, d, 32'h160 + i);
      end
    end
    ahb_read(A_RX, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL simul_empty: got %h, required 00000000", d); end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    addr_phase(A_TX, 1'b1);
    cyc();
    HWDATA = 32'h77;
    addr_phase(A_ST, 1'b0);
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL b2b_ready: hreadyout=%b, required 1", HREADYOUT); end
    cyc();
    idle_bus();
    @(negedge HCLK);
    checks++;
    if (HRDATA !== 32'h0 || tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      failures++; $display("FAIL b2b_status: hrdata=%h tx_valid=%b tx_data=%h, required 0/1/77", HRDATA, tx_valid, tx_data);
    end
    cyc();
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    @(negedge HCLK);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: tx_valid=%b, required 0", tx_valid); end
    cyc();
  endtask

  task automatic test_reset_mid_wait();
    int w;
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) ahb_write(A_TX, 32'hA0 + i, w);
    addr_phase(A_TX, 1'b1);
    cyc();
    idle_bus();
    HWDATA = 32'hA4;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL mid_wait_stall: hreadyout=%b, required 0", HREADYOUT); end
    cyc();
    HRESETn = 1'b0;
    cyc();
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL mid_wait_reset: hreadyout=%b tx_valid=%b, required 1/0", HREADYOUT, tx_valid);
    end
    cyc();
    HRESETn = 1'b1;
    cyc();
    ahb_read(A_ST, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL mid_wait_status: got %h, required 00000002", d); end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_tx_full_wait();
    test_rx_read();
    test_rx_overrun();
    test_rx_simultaneous();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahblite_uart_slave.md
# ahblite_uart_slave

AHB-Lite responder for the UART register window at 0x40000010–0x4000001F, selected by the system address decoder's UART select line. Converts AHB-Lite address/data-phase transfers into byte pushes and pops on two small synchronous FIFOs. A transmit FIFO drains to the UART core over a valid/ready handshake; a receive FIFO captures strobed bytes from the core. The block inserts wait states when software writes into a full transmit FIFO.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries per FIFO; power of two, ≥2.

Ports:
- HCLK  in  1  system clock; one clock domain only.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  address; only HADDR[3:2] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; byte lane [7:0] is used.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready (previous transfer completing).
- HREADYOUT  out  1  slave ready; 0 = wait state.
- HRDATA  out  32  read data, data phase.
- HRESP  out  1  tied 0 (OKAY).
- tx_data  out  8  byte to UART core.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  core accepts byte when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY. At that edge, register: active flag, HWRITE, HADDR[3:2]. If not accepted, the active flag clears.
- Register map (offset from 0x40000010):
  - 0x0 RX DATA, read: {23'b0, rx_nonempty, rx_head[7:0]}. Pops one entry at data-phase completion if nonempty. Read when empty returns 0 and does not pop. Writes ignored.
  - 0x4 TX STATE, read: bit0 tx_full, bit1 tx_empty, bit2 rx_overrun (sticky), bit3 rx_nonempty, others 0. Reading clears rx_overrun at data-phase completion. Writes ignored.
  - 0x8 TX DATA, write: pushes HWDATA[7:0]. Reads return 0.
  - 0xC: read 0, write ignored.
- TX FIFO head drives tx_data. tx_valid = tx FIFO nonempty. Pop on tx_valid & tx_ready.
- RX push on rx_valid. If the FIFO is full and no pop happens in the same cycle, the byte is dropped and rx_overrun is set.
- RX pop and push in the same cycle: both happen, count unchanged, including at full (no overrun).
- TX write-data push and core pop in the same cycle: both happen.
- HRDATA is combinational from the registered data-phase state and the FIFO head. It is 0 whenever no read data phase is active.

## Timing
- Reset (HRESETn=0 at HCLK edge): FIFOs empty, rx_overrun=0, active flag=0. Outputs after reset: HREADYOUT=1, HRDATA=0, tx_valid=0, tx_data=0.
- Reads: zero wait states. Data appears in the cycle after address acceptance.
- Write to TX DATA with the TX FIFO not full: zero wait states; push at the data-phase edge. Byte on tx_data/tx_valid the next cycle if the FIFO was empty (1-cycle latency).
- Write to TX DATA with the TX FIFO full:
  - HREADYOUT=0 for each cycle the FIFO remains full.
  - The cycle the core pops, HREADYOUT returns to 1 combinationally from the pop, and the push completes at that edge.
- Back-to-back transfers supported. A new address phase is only accepted when HREADY=1, so no address is captured during wait states.
- Reset mid-wait-state: the pending write is discarded and HREADYOUT=1 on the next cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

## Structure
- Package ahblite_uart_pkg:
  - offset constants: RX_DATA=2'd0, TX_STATE=2'd1, TX_DATA=2'd2;
  - status bit indices;
  - HTRANS NONSEQ/SEQ encodings.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty), instantiated twice with WIDTH=8. Its behaviour at full/empty when push and pop happen together must match the RX/TX rules above.

## Test plan
- Reset, then idle: HREADYOUT=1, HRDATA=0, tx_valid=0; TX STATE read returns 0x2.
- Write 0x41 to 0x40000018 with tx_ready=1: tx_valid high one cycle later, tx_data=0x41, popped; no wait states.
- tx_ready=0, write 5 bytes (FIFO_DEPTH=4): 5th write holds HREADYOUT=0. Raise tx_ready: HREADYOUT=1 the same cycle, and bytes emerge in order 1..5.
- Strobe rx_data 0x55 then 0xAA; read 0x40000010 twice: returns 0x155 then 0x1AA. A third read returns 0 with no pop.
- Strobe 5 bytes with no reads: TX STATE bit2=1 and the 5th byte is lost. A second TX STATE read shows bit2=0. RX reads return the first 4 bytes.
- With RX FIFO full, issue rx_valid in the same cycle as an RX DATA read completion: no overrun, count stays 4, and the new byte is read last.
